// File: rtl/reg_file_cfg_v2.sv
// Parametrised configuration register file: masked writes, pipelined reads,
// lockable exported registers, write acknowledge and error pulses.
module reg_file_cfg_v2 #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_EXPORT = 4,
   parameter int RD_LATENCY = 1,
   parameter logic [NUM_EXPORT*DATA_WIDTH-1:0] RST_VALUES = {8'h08, 8'h21, 8'h00, 8'h00}
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [ADDR_WIDTH-1:0]            Address,
   input  logic                             WrEn,
   input  logic                             RdEn,
   input  logic [DATA_WIDTH-1:0]            WrData,
   input  logic [DATA_WIDTH-1:0]            WrMask,
   output logic [DATA_WIDTH-1:0]            RdData,
   output logic                             RdData_Valid,
   output logic                             Wr_Ack,
   output logic                             Err,
   output logic                             Locked,
   output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_EXPORT
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LIM  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] EXPORT_LIM = (ADDR_WIDTH+1)'(NUM_EXPORT);

   // Reset image widened to the whole array so every cell indexes it uniformly.
   localparam logic [DEPTH*DATA_WIDTH-1:0] RST_IMAGE =
      {{((DEPTH-NUM_EXPORT)*DATA_WIDTH){1'b0}}, RST_VALUES};

   logic [DATA_WIDTH-1:0] reg_val [DEPTH];
   logic                  addr_in_range;
   logic                  addr_is_export;
   logic                  collision;
   logic                  wr_req;
   logic                  rd_req;
   logic                  wr_accept;
   logic                  wr_reject;
   logic                  lock_state;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  wr_ack_q;
   logic                  wr_err_q;

   assign addr_in_range  = ({1'b0, Address} < DEPTH_LIM);
   assign addr_is_export = ({1'b0, Address} < EXPORT_LIM);
   assign collision      = WrEn & RdEn;
   assign wr_req         = WrEn & ~RdEn;
   assign rd_req         = RdEn & ~WrEn;
   assign lock_state     = reg_val[DEPTH-1][0];

   // The lock register itself lives above the exported range, so it stays writable.
   assign wr_reject = wr_req & (~addr_in_range | (lock_state & addr_is_export));
   assign wr_accept = wr_req & ~wr_reject;

   genvar gi;

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] cell_q;
         logic [DATA_WIDTH-1:0] cell_d;
         logic                  wr_sel;

         assign wr_sel = wr_accept && (Address == ADDR_WIDTH'(gi));
         assign cell_d = (cell_q & ~WrMask) | (WrData & WrMask);

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               cell_q <= RST_IMAGE[gi*DATA_WIDTH +: DATA_WIDTH];
            end else if (wr_sel) begin
               cell_q <= cell_d;
            end
         end

         assign reg_val[gi] = cell_q;
      end

      for (gi = 0; gi < NUM_EXPORT; gi++) begin : g_export
         assign REG_EXPORT[gi*DATA_WIDTH +: DATA_WIDTH] = reg_val[gi];
      end
   endgenerate

   // Unimplemented addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (Address == ADDR_WIDTH'(i)) begin
            rd_mux = reg_val[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         wr_ack_q <= wr_accept;
         wr_err_q <= collision | wr_reject;
      end
   end

   logic                  pipe_vld_d  [RD_LATENCY];
   logic                  pipe_err_d  [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_data_d [RD_LATENCY];
   logic                  pipe_vld_q  [RD_LATENCY];
   logic                  pipe_err_q  [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

   // Data stages only load on a valid, so the last stage holds the last returned value.
   generate
      for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
         logic                  vld_q;
         logic                  err_q;
         logic [DATA_WIDTH-1:0] data_q;

         if (gi == 0) begin : g_head
            assign pipe_vld_d[gi]  = rd_req;
            assign pipe_err_d[gi]  = rd_req & ~addr_in_range;
            assign pipe_data_d[gi] = rd_mux;
         end else begin : g_body
            assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
            assign pipe_err_d[gi]  = pipe_err_q[gi-1];
            assign pipe_data_d[gi] = pipe_data_q[gi-1];
         end

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               vld_q  <= 1'b0;
               err_q  <= 1'b0;
               data_q <= '0;
            end else begin
               vld_q <= pipe_vld_d[gi];
               err_q <= pipe_vld_d[gi] & pipe_err_d[gi];
               if (pipe_vld_d[gi]) begin
                  data_q <= pipe_data_d[gi];
               end
            end
         end

         assign pipe_vld_q[gi]  = vld_q;
         assign pipe_err_q[gi]  = err_q;
         assign pipe_data_q[gi] = data_q;
      end
   endgenerate

   assign RdData       = pipe_data_q[RD_LATENCY-1];
   assign RdData_Valid = pipe_vld_q[RD_LATENCY-1];
   assign Wr_Ack       = wr_ack_q;
   assign Err          = wr_err_q | pipe_err_q[RD_LATENCY-1];
   assign Locked       = lock_state;

endmodule

// File: tb/tb_reg_file_cfg_v2.sv
// Scoreboard bench for reg_file_cfg_v2: three configurations (latency 3, depth 12
// with latency 1, latency 2 for reset-during-read), directed vectors.
module tb_reg_file_cfg_v2;

   typedef struct {
      int         inst;
      int         cyc;
      bit         vld;
      bit         ack;
      bit         err;
      logic [7:0] data;
   } exp_t;

   localparam int LAT [3] = '{3, 1, 2};

   logic        clk;
   logic        rst_n   [3];
   logic [3:0]  addr    [3];
   logic        wr_en   [3];
   logic        rd_en   [3];
   logic [7:0]  wdata   [3];
   logic [7:0]  wmask   [3];
   logic [7:0]  rd_data [3];
   logic        rd_vld  [3];
   logic        wr_ack  [3];
   logic        err     [3];
   logic        locked  [3];
   logic [31:0] exp_o   [3];

   exp_t        sb [$];
   int          cyc;
   int          checks;
   int          errors;
   logic [7:0]  last_data [3];

   reg_file_cfg_v2 #(.DEPTH(16), .RD_LATENCY(3)) u_lat3 (
      .CLK(clk), .RST(rst_n[0]), .Address(addr[0]), .WrEn(wr_en[0]), .RdEn(rd_en[0]),
      .WrData(wdata[0]), .WrMask(wmask[0]), .RdData(rd_data[0]), .RdData_Valid(rd_vld[0]),
      .Wr_Ack(wr_ack[0]), .Err(err[0]), .Locked(locked[0]), .REG_EXPORT(exp_o[0]));

   reg_file_cfg_v2 #(.DEPTH(12), .RD_LATENCY(1)) u_d12 (
      .CLK(clk), .RST(rst_n[1]), .Address(addr[1]), .WrEn(wr_en[1]), .RdEn(rd_en[1]),
      .WrData(wdata[1]), .WrMask(wmask[1]), .RdData(rd_data[1]), .RdData_Valid(rd_vld[1]),
      .Wr_Ack(wr_ack[1]), .Err(err[1]), .Locked(locked[1]), .REG_EXPORT(exp_o[1]));

   reg_file_cfg_v2 #(.DEPTH(16), .RD_LATENCY(2)) u_lat2 (
      .CLK(clk), .RST(rst_n[2]), .Address(addr[2]), .WrEn(wr_en[2]), .RdEn(rd_en[2]),
      .WrData(wdata[2]), .WrMask(wmask[2]), .RdData(rd_data[2]), .RdData_Valid(rd_vld[2]),
      .Wr_Ack(wr_ack[2]), .Err(err[2]), .Locked(locked[2]), .REG_EXPORT(exp_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: merge every expectation maturing this cycle and compare to outputs.
   bit         mon_v, mon_a, mon_e;
   logic [7:0] mon_d;
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         mon_v = 1'b0;
         mon_a = 1'b0;
         mon_e = 1'b0;
         mon_d = last_data[i];
         for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].inst == i && sb[j].cyc == cyc) begin
               mon_v |= sb[j].vld;
               mon_a |= sb[j].ack;
               mon_e |= sb[j].err;
               if (sb[j].vld) mon_d = sb[j].data;
               sb.delete(j);
            end
         end
         if (mon_v) last_data[i] = mon_d;
         if (mon_v || mon_a || mon_e || rd_vld[i] || wr_ack[i] || err[i]) begin
            checks++;
            if ({rd_vld[i], wr_ack[i], err[i]} !== {mon_v, mon_a, mon_e} || rd_data[i] !== mon_d) begin
               errors++;
               $display("FAIL resp inst%0d cyc%0d: got vld=%b ack=%b err=%b data=%h, need vld=%b ack=%b err=%b data=%h",
                        i, cyc, rd_vld[i], wr_ack[i], err[i], rd_data[i], mon_v, mon_a, mon_e, mon_d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] need);
      checks++;
      if (act !== need) begin
         errors++;
         $display("FAIL %s: got %h, need %h", name, act, need);
      end
   endtask

   task automatic drive(input int i, input bit w, input bit r, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] m);
      @(negedge clk);
      wr_en[i] = w;
      rd_en[i] = r;
      addr[i]  = a;
      wdata[i] = d;
      wmask[i] = m;
   endtask

   task automatic push(input int i, input int at, input bit v, input bit a, input bit e,
                       input logic [7:0] d);
      sb.push_back('{inst: i, cyc: at, vld: v, ack: a, err: e, data: d});
   endtask

   task automatic rd(input int i, input logic [3:0] a, input logic [7:0] d, input bit e);
      drive(i, 1'b0, 1'b1, a, 8'h00, 8'h00);
      push(i, cyc + LAT[i], 1'b1, 1'b0, e, d);
   endtask

   task automatic wr(input int i, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] m, input bit ok);
      drive(i, 1'b1, 1'b0, a, d, m);
      push(i, cyc + 1, 1'b0, ok, !ok, 8'h00);
   endtask

   task automatic collide(input int i, input logic [3:0] a, input logic [7:0] d);
      drive(i, 1'b1, 1'b1, a, d, 8'hFF);
      push(i, cyc + 1, 1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic idle(input int i, input int n);
      repeat (n) drive(i, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
   endtask

   task automatic chk_rst_outs(input int i, input string name);
      chk(name, {20'h0, rd_vld[i], wr_ack[i], err[i], locked[i], rd_data[i]}, 32'h0);
   endtask

   initial begin
      cyc    = 0;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; addr[i] = '0; wr_en[i] = 1'b0; rd_en[i] = 1'b0;
         wdata[i] = '0; wmask[i] = '0; last_data[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_rst_outs(i, "reset_outputs");
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      for (int i = 0; i < 3; i++) chk($sformatf("reset_export%0d", i), exp_o[i], 32'h0821_0000);

      // Latency 3: pipelined reads, with a write slipped between them.
      rd(0, 4'd0, 8'h00, 1'b0);
      rd(0, 4'd1, 8'h00, 1'b0);
      rd(0, 4'd2, 8'h21, 1'b0);
      wr(0, 4'd2, 8'h77, 8'hFF, 1'b1);
      rd(0, 4'd3, 8'h08, 1'b0);
      rd(0, 4'd0, 8'h00, 1'b0);
      rd(0, 4'd1, 8'h00, 1'b0);
      rd(0, 4'd2, 8'h77, 1'b0);
      rd(0, 4'd3, 8'h08, 1'b0);
      idle(0, 1);
      chk("export_after_write", exp_o[0], 32'h0877_0000);
      // Masked writes, including an all-zero mask.
      wr(0, 4'd5, 8'hA0, 8'hFF, 1'b1);
      wr(0, 4'd5, 8'hFF, 8'h0F, 1'b1);
      rd(0, 4'd5, 8'hAF, 1'b0);
      wr(0, 4'd5, 8'h00, 8'h00, 1'b1);
      rd(0, 4'd5, 8'hAF, 1'b0);
      // Lock takes effect on the very next request.
      wr(0, 4'd15, 8'h01, 8'hFF, 1'b1);
      wr(0, 4'd1, 8'h55, 8'hFF, 1'b0);
      wr(0, 4'd6, 8'h3C, 8'hFF, 1'b1);
      rd(0, 4'd1, 8'h00, 1'b0);
      idle(0, 1);
      chk("locked_set", {31'h0, locked[0]}, 32'h1);
      chk("locked_export", exp_o[0], 32'h0877_0000);
      rd(0, 4'd6, 8'h3C, 1'b0);
      wr(0, 4'd15, 8'h00, 8'hFF, 1'b1);
      wr(0, 4'd1, 8'h55, 8'hFF, 1'b1);
      idle(0, 1);
      chk("unlocked", {31'h0, locked[0]}, 32'h0);
      chk("unlocked_export", exp_o[0], 32'h0877_5500);
      wr(0, 4'd15, 8'hA4, 8'hFF, 1'b1);
      rd(0, 4'd15, 8'hA4, 1'b0);
      collide(0, 4'd3, 8'hEE);
      idle(0, 4);
      chk("collision_export", exp_o[0], 32'h0877_5500);
      chk("lock_gp_bits", {31'h0, locked[0]}, 32'h0);

      // Depth 12, latency 1: out-of-range accesses and the relocated lock register.
      rd(1, 4'd2, 8'h21, 1'b0);
      rd(1, 4'd9, 8'h00, 1'b0);
      rd(1, 4'd13, 8'h00, 1'b1);
      rd(1, 4'd2, 8'h21, 1'b0);
      wr(1, 4'd14, 8'hAA, 8'hFF, 1'b0);
      wr(1, 4'd11, 8'h5A, 8'hFF, 1'b1);
      rd(1, 4'd11, 8'h5A, 1'b0);
      wr(1, 4'd12, 8'h33, 8'hFF, 1'b0);
      rd(1, 4'd12, 8'h00, 1'b1);
      wr(1, 4'd11, 8'h01, 8'h01, 1'b1);
      wr(1, 4'd0, 8'hFF, 8'hFF, 1'b0);
      rd(1, 4'd11, 8'h5B, 1'b0);
      idle(1, 2);
      chk("d12_locked", {31'h0, locked[1]}, 32'h1);
      chk("d12_export", exp_o[1], 32'h0821_0000);

      // Latency 2: reset asserted while a read is in flight.
      wr(2, 4'd7, 8'hC3, 8'hFF, 1'b1);
      wr(2, 4'd0, 8'h99, 8'hFF, 1'b1);
      rd(2, 4'd7, 8'hC3, 1'b0);
      idle(2, 3);
      chk("lat2_export", exp_o[2], 32'h0821_0099);
      rd(2, 4'd0, 8'h99, 1'b0);
      @(negedge clk);
      rd_en[2] = 1'b0;
      #2;
      rst_n[2] = 1'b0;
      for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == 2) sb.delete(j);
      last_data[2] = 8'h00;
      repeat (2) @(negedge clk);
      chk_rst_outs(2, "midread_reset_outputs");
      rst_n[2] = 1'b1;
      idle(2, 2);
      chk("midread_export", exp_o[2], 32'h0821_0000);
      rd(2, 4'd7, 8'h00, 1'b0);
      rd(2, 4'd0, 8'h00, 1'b0);
      idle(2, 4);

      for (int i = 0; i < 3; i++) idle(i, 1);
      chk("scoreboard_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
